// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock and only then
// releases the downstream reset, retrying a bounded number of times before giving up.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 2700,
    parameter int STABLE_CYCLES  = 270,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock_async,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync1_q, lock_s_q;
    logic [3:0]      retry_q, retry_d, retry_inc_s;
    logic            lost_q, lost_d;
    logic            pll_reset_q, sys_reset_q, ready_q, fail_q;

    // Lock synchronizer, FSM state, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= ST_RST_PLL;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            lost_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            sync1_q     <= lock_async;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            // Outputs follow the state being entered so they change on the entry edge
            pll_reset_q <= (state_d == ST_RST_PLL);
            sys_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    // Next-state, retry bookkeeping and cycle counter
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lost_d      = lost_q;
        retry_inc_s = (retry_q == 4'd15) ? 4'd15 : (retry_q + 4'd1);
        case (state_q)
            ST_RST_PLL: begin
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_RST_PLL;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle takes priority over the retry
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc_s;
                    if ((MAX_RETRIES != 0) && (retry_inc_s == 4'(MAX_RETRIES))) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_RST_PLL;
                    end
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end else begin
                    state_d = ST_STABLE;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    lost_d  = 1'b1;
                    state_d = ST_RST_PLL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST_PLL;
            end
        endcase
        cnt_d = (state_d != state_q) ? '0 : (cnt_q + CW'(1));
    end

    assign pll_reset   = pll_reset_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign lock_lost   = lost_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: vector table, directed corner
// sequences and a randomized lock pattern checked against a timestamp-based model.
module tb_pll_lock_supervisor;

    localparam int PRC = 8;
    localparam int LTO = 100;
    localparam int SCY = 16;
    localparam int MRT = 3;

    localparam int P_PULSE  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    localparam logic [8:0] RST_VEC = 9'b1_1_0_0_0_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lock_async = 1'b0;
    logic       pll_reset, sys_reset, ready, fail, lock_lost;
    logic [3:0] retry_count;

    int total = 0;
    int bad   = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .STABLE_CYCLES (SCY),
        .MAX_RETRIES   (MRT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lock_async (lock_async),
        .pll_reset  (pll_reset),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus the time it was entered; lock seen two edges late
    int m_ph    = P_PULSE;
    int m_t0    = 1;
    int m_t     = 0;
    int m_retry = 0;
    bit m_lost  = 1'b0;
    bit m_hist[$];

    function automatic void model_step(input bit rst, input bit lk_in);
        bit lk;
        int el;
        if (rst) begin
            m_ph    = P_PULSE;
            m_t0    = m_t + 1;
            m_retry = 0;
            m_lost  = 1'b0;
            m_hist.delete();
        end else begin
            lk = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
            el = m_t - m_t0;
            case (m_ph)
                P_PULSE: if (el == PRC - 1) begin m_ph = P_WAIT; m_t0 = m_t + 1; end
                P_WAIT: begin
                    if (lk) begin
                        m_ph = P_STABLE; m_t0 = m_t + 1;
                    end else if (el == LTO - 1) begin
                        m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
                        m_ph = (MRT != 0 && m_retry == MRT) ? P_FAIL : P_PULSE;
                        m_t0 = m_t + 1;
                    end
                end
                P_STABLE: begin
                    if (!lk) begin
                        m_ph = P_WAIT; m_t0 = m_t + 1;
                    end else if (el == SCY - 1) begin
                        m_ph = P_RUN; m_t0 = m_t + 1; m_retry = 0;
                    end
                end
                P_RUN: if (!lk) begin m_lost = 1'b1; m_ph = P_PULSE; m_t0 = m_t + 1; end
                default: ;
            endcase
            m_hist.push_back(lk_in);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
        end
        m_t = m_t + 1;
    endfunction

    function automatic logic [8:0] model_vec();
        return {m_ph == P_PULSE, m_ph != P_RUN, m_ph == P_RUN, m_ph == P_FAIL,
                m_lost, 4'(m_retry)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {pll_reset, sys_reset, ready, fail, lock_lost, retry_count};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // One clock: advance the model, let the DUT take the edge, compare on the falling edge
    task automatic tick();
        model_step(reset, lock_async);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL model t=%0d got=%b expected=%b (pll,sys,rdy,fail,lost,retry)",
                     m_t, dut_vec(), model_vec());
        end
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        bit         lk;
        int         n;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pll_hi, rises, rise1, rise2, fail_k, seg, fail_age;
        logic prev;

        // Normal lock, then lock loss in RUN and relock; {pll,sys,rdy,fail,lost,retry}
        tbl[0]  = '{1'b1, 1'b0, 2,  RST_VEC};
        tbl[1]  = '{1'b0, 1'b0, 7,  9'b1_1_0_0_0_0000};
        tbl[2]  = '{1'b0, 1'b0, 1,  9'b0_1_0_0_0_0000};
        tbl[3]  = '{1'b0, 1'b0, 40, 9'b0_1_0_0_0_0000};
        tbl[4]  = '{1'b0, 1'b1, 18, 9'b0_1_0_0_0_0000};
        tbl[5]  = '{1'b0, 1'b1, 1,  9'b0_0_1_0_0_0000};
        tbl[6]  = '{1'b0, 1'b0, 1,  9'b0_0_1_0_0_0000};
        tbl[7]  = '{1'b0, 1'b0, 1,  9'b0_0_1_0_0_0000};
        tbl[8]  = '{1'b0, 1'b0, 1,  9'b1_1_0_0_1_0000};
        tbl[9]  = '{1'b0, 1'b1, 8,  9'b0_1_0_0_1_0000};
        tbl[10] = '{1'b0, 1'b1, 1,  9'b0_1_0_0_1_0000};
        tbl[11] = '{1'b0, 1'b1, 15, 9'b0_1_0_0_1_0000};
        tbl[12] = '{1'b0, 1'b1, 1,  9'b0_0_1_0_1_0000};
        tbl[13] = '{1'b1, 1'b1, 1,  RST_VEC};

        for (int i = 0; i < 14; i++) begin
            reset      = tbl[i].rst;
            lock_async = tbl[i].lk;
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d", i), int'(dut_vec()), int'(tbl[i].exp));
        end

        // Never lock: three pulses, then FAIL 324 edges after release
        lock_async = 1'b0;
        hold_reset(2);
        pll_hi = pll_reset ? 1 : 0;
        rises = 0; rise1 = -1; rise2 = -1; fail_k = -1;
        prev = pll_reset;
        for (int k = 1; k <= 380; k++) begin
            tick();
            if (pll_reset) pll_hi++;
            if (pll_reset && !prev) begin
                rises++;
                if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
            end
            prev = pll_reset;
            if (fail && fail_k < 0) fail_k = k;
            if (k == 110) chk("retry_attempt2", int'(retry_count), 1);
            if (k == 220) chk("retry_attempt3", int'(retry_count), 2);
        end
        chk("nolock_pll_high_cycles", pll_hi, 3 * PRC);
        chk("nolock_pll_rises", rises, 2);
        chk("nolock_rise1", rise1, 108);
        chk("nolock_rise2", rise2, 216);
        chk("nolock_fail_edge", fail_k, 324);
        chk("nolock_final", int'(dut_vec()), int'(9'b0_1_0_1_0_0011));

        // Reset while in FAIL, then a clean lock
        reset = 1'b1;
        tick();
        chk("reset_in_fail", int'(dut_vec()), int'(RST_VEC));
        reset = 1'b0;
        lock_async = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 24) chk("after_fail_sys_hold", int'(sys_reset), 1);
            if (k == 25) chk("after_fail_run", int'(dut_vec()), int'(9'b0_0_1_0_0_0000));
        end

        // Lock on the second attempt
        lock_async = 1'b0;
        hold_reset(2);
        for (int k = 1; k <= 175; k++) begin
            lock_async = (k >= 150);
            tick();
            if (k == 149) chk("second_retry1", int'(dut_vec()), int'(9'b0_1_0_0_0_0001));
            if (k == 167) chk("second_stable", int'(dut_vec()), int'(9'b0_1_0_0_0_0001));
            if (k == 168) chk("second_run", int'(dut_vec()), int'(9'b0_0_1_0_0_0000));
        end

        // Lock bounce in STABLE requires a full stable window again
        lock_async = 1'b0;
        hold_reset(2);
        for (int k = 1; k <= 60; k++) begin
            lock_async = ((k >= 20) && (k <= 32)) || (k >= 38);
            tick();
            if (k == 38) chk("bounce_no_early_release", int'(sys_reset), 1);
            if (k == 40) chk("bounce_retry_same", int'(retry_count), 0);
            if (k == 55) chk("bounce_sys_hold", int'(sys_reset), 1);
            if (k == 56) chk("bounce_release", int'(dut_vec()), int'(9'b0_0_1_0_0_0000));
        end

        // Reset while in STABLE
        lock_async = 1'b0;
        hold_reset(2);
        for (int k = 1; k <= 25; k++) begin
            lock_async = (k >= 20);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("reset_in_stable", int'(dut_vec()), int'(RST_VEC));
        reset = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 24) chk("restart_sys_hold", int'(sys_reset), 1);
            if (k == 25) chk("restart_run", int'(dut_vec()), int'(9'b0_0_1_0_0_0000));
        end

        // Randomized lock segments with occasional resets, checked by the model every cycle
        seg = 0;
        fail_age = 0;
        for (int c = 0; c < 5000; c++) begin
            if (seg == 0) begin
                lock_async = 1'($urandom_range(0, 1));
                seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 400))
                                                  : int'($urandom_range(1, 30));
            end
            seg--;
            fail_age = (m_ph == P_FAIL) ? fail_age + 1 : 0;
            reset = (fail_age > 40) || ($urandom_range(0, 799) == 0);
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the on-chip rPLL from its reference-clock domain: it drives the PLL's RESET input and watches the PLL's LOCK output. It holds the fast-clock logic in reset until lock has been stable for a programmed time. If lock does not arrive, it re-pulses the PLL reset, and it gives up after a bounded number of attempts. The block sits between the 27 MHz board clock input and the PLL instance, and feeds the system reset tree of the display/debug logic.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 8: width of each PLL reset pulse, in clk cycles (≥1).
- `LOCK_TIMEOUT`, 2700: clk cycles to wait for lock after the PLL reset is released (≥2).
- `STABLE_CYCLES`, 270: consecutive clk cycles that synchronized lock must stay high before release (≥1).
- `MAX_RETRIES`, 3: number of lock timeouts before FAIL. 0 means retry forever.

Ports:
- `clk`, in, 1: 27 MHz reference clock, the same net that drives the PLL's clkin.
- `reset`, in, 1: synchronous, active-high reset.
- `lock_async`, in, 1: PLL LOCK output. Asynchronous to `clk`.
- `pll_reset`, out, 1: drives the PLL RESET input. Active high.
- `sys_reset`, out, 1: active-high reset for downstream logic.
- `ready`, out, 1: PLL locked and stable; equals `!sys_reset && !fail`.
- `fail`, out, 1: lock could not be obtained. Sticky until `reset`.
- `lock_lost`, out, 1: sticky flag. Set when lock drops while in RUN.
- `retry_count`, out, 4: number of lock timeouts since the last `reset` or the last entry into RUN. Saturates at 15.

## Operation
- `lock_async` passes through a 2-FF synchronizer to give `lock_s`. The FSM uses only `lock_s`.
- One cycle counter, wide enough for max(`PLL_RST_CYCLES`, `LOCK_TIMEOUT`, `STABLE_CYCLES`). It is cleared on every state entry and increments every cycle otherwise.
- FSM states and transitions:
  - RST_PLL: `pll_reset`=1, `sys_reset`=1. When count==`PLL_RST_CYCLES`-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_reset`=0, `sys_reset`=1.
    - If `lock_s`=1, go to STABLE.
    - Else if count==`LOCK_TIMEOUT`-1, increment `retry_count`. Go to FAIL if `MAX_RETRIES`≠0 and the new `retry_count`==`MAX_RETRIES`; otherwise go to RST_PLL.
    - If lock and timeout occur on the same cycle, lock wins.
  - STABLE: `sys_reset`=1.
    - If `lock_s`=0, go back to WAIT_LOCK. The timeout restarts and `retry_count` is unchanged.
    - Else if count==`STABLE_CYCLES`-1, go to RUN.
  - RUN: `sys_reset`=0, `ready`=1, and `retry_count` is cleared.
    - If `lock_s`=0, set `lock_lost` and go to RST_PLL. This is not counted as a retry.
  - FAIL: `pll_reset`=0, `sys_reset`=1, `fail`=1. Terminal until `reset`.
- Reset values:
  - state=RST_PLL, counter=0, synchronizer flops=0.
  - `pll_reset`=1, `sys_reset`=1, `ready`=0, `fail`=0, `lock_lost`=0, `retry_count`=0.
- `reset` asserted in any state, including mid-operation, returns the block to these values on the next edge.

## Timing
- All outputs are registered. They take their new-state values on the same edge that enters the state.
- `pll_reset` pulse width is exactly `PLL_RST_CYCLES` cycles.
- WAIT_LOCK with no lock lasts exactly `LOCK_TIMEOUT` cycles.
- Release latency: let E0 be the first edge that samples `lock_async`=1 while in WAIT_LOCK.
  - `lock_s` is high after E1.
  - STABLE is entered at E2.
  - RUN is entered at E2+`STABLE_CYCLES`, so `sys_reset` falls `STABLE_CYCLES`+2 edges after E0.
- Lock-loss latency: `lock_async` falling at E0 gives RUN→RST_PLL at E2, so `sys_reset` and `pll_reset` rise 2 edges after E0.
- Lock glitches shorter than one `clk` period may be missed. This is acceptable.

## Test plan
Common parameters: `PLL_RST_CYCLES`=8, `LOCK_TIMEOUT`=100, `STABLE_CYCLES`=16, `MAX_RETRIES`=3.
- **Normal lock.** Release `reset` and raise `lock_async` 40 cycles after `pll_reset` falls.
  - `pll_reset` is high for exactly 8 cycles.
  - `sys_reset` falls 18 edges after lock is first sampled.
  - `ready`=1, `retry_count`=0.
- **Never lock.**
  - Exactly 3 `pll_reset` pulses, each 8 cycles, spaced 100 cycles apart.
  - `fail` rises 324 cycles after reset release.
  - `retry_count`=3, and it stays in FAIL with `sys_reset`=1.
- **Lock on the second attempt.**
  - `retry_count`=1 during the second attempt.
  - It clears to 0 when RUN is entered.
- **Lock bounce in STABLE.** Drop `lock_async` at count 10.
  - The FSM returns to WAIT_LOCK and `retry_count` is unchanged.
  - After lock is re-raised, the full 16-cycle stable window is required again.
- **Lock loss in RUN.** Drop `lock_async` while in RUN.
  - `sys_reset`=1 and `pll_reset`=1 two edges later.
  - `lock_lost`=1, and it stays set after relock.
  - `ready` returns after the full sequence.
- **Reset mid-operation.** Assert `reset` in STABLE, and separately in FAIL.
  - Next edge: all outputs equal the reset values.
  - The sequence restarts with `fail`=0 and `lock_lost`=0.
